lockin_sample_fifo: RTL

//  Buffers lock-in amplifier results (X, Y) between the lock-in stage and the

---
 rtl/lockin_sample_fifo.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lockin_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lockin_sample_fifo
// Purpose  : Buffers lock-in (X, Y) results between the lock-in stage and the
//            processor readout. Each result is tagged with a free-running
//            32-bit sequence number. When the FIFO is full, the newest sample
//            is dropped and counted.
// Ports    : clk_i, reset_ni (async, active low)
//            tick_i, x_i, y_i   - push strobe and signed X/Y sample
//            rd_i, clear_i      - pop request and synchronous flush
//            x_o, y_o, seq_o    - last popped entry, held until next pop
//            rd_valid_o         - 1-cycle pulse after a successful pop
//            empty_o, full_o,
//            level_o            - registered occupancy status
//            drop_cnt_o         - saturating count of rejected ticks
// Revision : 1.0 - initial release
// ============================================================================
module lockin_sample_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     tick_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic                     rd_i,
  input  logic                     clear_i,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [DATA_W-1:0] y_o,
  output logic        [31:0]       seq_o,
  output logic                     rd_valid_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic        [LVL_W-1:0]  level_o,
  output logic        [31:0]       drop_cnt_o
);

  localparam int C_ADDR_W = $clog2(DEPTH);

  // Storage is deliberately left without reset.
  logic [DATA_W-1:0] r_mem_x   [DEPTH];
  logic [DATA_W-1:0] r_mem_y   [DEPTH];
  logic [31:0]       r_mem_seq [DEPTH];

  // Pointers carry one extra bit so that full and empty can be told apart.
  logic [C_ADDR_W:0]   r_wr_ptr;
  logic [C_ADDR_W:0]   r_rd_ptr;
  logic [31:0]         r_seq;
  logic [31:0]         r_drop_cnt;
  logic [LVL_W-1:0]    r_level;
  logic                r_empty;
  logic                r_full;
  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_y;
  logic [31:0]         r_seq_out;
  logic                r_rd_valid;

  logic                w_ptr_empty;
  logic                w_ptr_full;
  logic                w_do_rd;
  logic                w_do_wr;
  logic                w_do_drop;
  logic                w_tick;
  logic [LVL_W-1:0]    w_level_nxt;

  assign w_ptr_empty = (r_wr_ptr == r_rd_ptr);
  assign w_ptr_full  = (r_wr_ptr[C_ADDR_W] != r_rd_ptr[C_ADDR_W]) &&
                       (r_wr_ptr[C_ADDR_W-1:0] == r_rd_ptr[C_ADDR_W-1:0]);

  // A flush swallows any same-cycle tick or pop entirely.
  assign w_tick    = tick_i && !clear_i;
  assign w_do_rd   = rd_i && !clear_i && !w_ptr_empty;
  // When full, a same-cycle pop frees the slot being written.
  assign w_do_wr   = w_tick && (!w_ptr_full || w_do_rd);
  assign w_do_drop = w_tick && w_ptr_full && !rd_i;

  always_comb begin
    w_level_nxt = r_level;
    if (clear_i) begin
      w_level_nxt = '0;
    end else if (w_do_wr && !w_do_rd) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_do_wr && w_do_rd) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_wr) begin
      r_mem_x[r_wr_ptr[C_ADDR_W-1:0]]   <= x_i;
      r_mem_y[r_wr_ptr[C_ADDR_W-1:0]]   <= y_i;
      r_mem_seq[r_wr_ptr[C_ADDR_W-1:0]] <= r_seq;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_seq_out  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_level    <= w_level_nxt;
      r_empty    <= (w_level_nxt == '0);
      r_full     <= (w_level_nxt == LVL_W'(DEPTH));
      r_rd_valid <= w_do_rd;

      // Sequence numbers advance on every tick, accepted or dropped.
      if (w_tick) begin
        r_seq <= r_seq + 32'd1;
      end

      if (w_do_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end

      if (w_do_rd) begin
        r_x       <= r_mem_x[r_rd_ptr[C_ADDR_W-1:0]];
        r_y       <= r_mem_y[r_rd_ptr[C_ADDR_W-1:0]];
        r_seq_out <= r_mem_seq[r_rd_ptr[C_ADDR_W-1:0]];
      end

      if (clear_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_do_rd) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  assign x_o        = r_x;
  assign y_o        = r_y;
  assign seq_o      = r_seq_out;
  assign rd_valid_o = r_rd_valid;
  assign empty_o    = r_empty;
  assign full_o     = r_full;
  assign level_o    = r_level;
  assign drop_cnt_o = r_drop_cnt;

endmodule
`default_nettype wire
